sifh_peak_finder: RTL and testbench
===================================

SIFH_PEAK_FINDER -- requirements
Module: sifh_peak_finder

Interface
REQ-001 SHALL have parameter NB, default 8, histogram bin address width (2^NB bins).
REQ-002 SHALL have parameter PEAK_MAX, default 16, bin count width.
REQ-003 SHALL have port clk  input  1  single clock for all logic, rising edge.
REQ-004 SHALL have port res  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  request one scan of the histogram RAM, sampled in IDLE only.
REQ-006 SHALL have port minCount  input  PEAK_MAX  noise threshold for peak validity.
REQ-007 SHALL have port counts  input  PEAK_MAX  RAM port-b read data, 1-cycle read latency.
REQ-008 SHALL have port raddr  output  NB  RAM port-b address.
REQ-009 SHALL have ports rEnable, readFlag  output  1 each  port-b enable and memory enable, high while reading.
REQ-010 SHALL have port waddr  output  NB  RAM port-a address for clear writes.
REQ-011 SHALL have ports wEnable, writeFlag  output  1 each  port-a write enable and memory enable.
REQ-012 SHALL have port wdata  output  PEAK_MAX  port-a write data, constant 0.
REQ-013 SHALL have port peakAddr  output  NB  bin index of maximum count.
REQ-014 SHALL have port peakCount  output  PEAK_MAX  maximum count found.
REQ-015 SHALL have port peakValid  output  1  peakCount > minCount.
REQ-016 SHALL have ports busy, done  output  1 each  scan in progress, and one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, READ, DRAIN, DONE; IDLE->READ on start, READ->DRAIN after raddr = 2^NB-1 is issued, DRAIN->DONE, DONE->IDLE unconditionally.
REQ-018 SHALL drive all outputs from registers.
REQ-019 SHALL, in READ, issue raddr 0,1,...,2^NB-1 on consecutive cycles with rEnable = readFlag = 1; both SHALL be 0 in every other state.
REQ-020 SHALL evaluate counts in the cycle after each address is issued, pairing it with that address via a one-stage delayed address and valid flag.
REQ-021 SHALL, at scan start, clear the running maximum to 0 and the running address to 0.
REQ-022 SHALL update the running maximum only when counts is strictly greater, so the lowest address wins on ties.
REQ-023 SHALL, for an all-zero histogram, report peakAddr = 0, peakCount = 0, peakValid = 0.
REQ-024 SHALL load peakAddr, peakCount and peakValid on entry to DONE, pulse done high for exactly one cycle, and hold these outputs until the next accepted start.
REQ-025 SHALL assert done exactly 2^NB+2 cycles after the edge at which start was sampled.
REQ-026 SHALL hold busy high from the cycle after start is accepted through DRAIN, and low in DONE and IDLE.
REQ-027 SHALL ignore start while busy or in DONE, with no queuing.
REQ-028 SHALL compare peakCount > minCount as unsigned, full PEAK_MAX width, with no saturation or wrap.

Reset
REQ-029 SHALL, on res high, asynchronously force state IDLE and set raddr, waddr, rEnable, readFlag, wEnable, writeFlag, wdata, peakAddr, peakCount, peakValid, busy and done to 0.
REQ-030 SHALL, on res mid-scan, abort the scan with no done pulse, and leave the next scan unaffected by the aborted one.

Configuration
REQ-031 SHALL recognise macro SIFH_CLEAR_ON_READ_EN.
REQ-032 SHALL, with SIFH_CLEAR_ON_READ_EN defined, write 0 to each bin in the cycle its data is evaluated: waddr = delayed address, wEnable = writeFlag = 1, so that the histogram is zeroed by DONE.
REQ-033 SHALL, without SIFH_CLEAR_ON_READ_EN, hold waddr, wEnable, writeFlag and wdata at 0 permanently, leaving RAM contents unchanged.

Verification
REQ-034 SHALL cover: NB=8, bin 37 = 90 and all others < 90, minCount = 10, start -> peakAddr = 37, peakCount = 90, peakValid = 1, done at cycle 258.
REQ-035 SHALL cover: bins 5 and 200 both = 50 (maximum) -> peakAddr = 5, peakCount = 50.
REQ-036 SHALL cover: all bins 0, minCount = 0 -> peakAddr = 0, peakCount = 0, peakValid = 0, done still pulses once.
REQ-037 SHALL cover: res asserted at raddr = 100, then released and start issued -> no done before the second scan; second scan result correct; outputs 0 during reset.
REQ-038 SHALL cover: start held high for the whole scan -> exactly one done; with SIFH_CLEAR_ON_READ_EN, a second scan returns peakCount = 0 and the RAM model reads all zeros.

Source files
------------

// File: rtl/sifh_peak_finder.sv
// rtl/sifh_peak_finder.sv - scans a histogram RAM and reports the bin with the largest count
//
// Optional build macro: SIFH_CLEAR_ON_READ_EN - zero each bin as its count is evaluated.
//
// Ports:
//   clk        rising-edge clock
//   res        asynchronous active-high reset
//   start      request one scan (sampled in IDLE only)
//   minCount   noise threshold; peakValid = peakCount > minCount
//   counts     RAM port-b read data, one cycle after raddr/rEnable
//   raddr      RAM port-b address
//   rEnable    RAM port-b enable
//   readFlag   RAM port-b memory enable (same as rEnable)
//   waddr      RAM port-a address for clear writes
//   wEnable    RAM port-a write enable
//   writeFlag  RAM port-a memory enable (same as wEnable)
//   wdata      RAM port-a write data (always 0)
//   peakAddr   bin index of the maximum count
//   peakCount  maximum count found
//   peakValid  peakCount > minCount
//   busy       scan in progress (READ and DRAIN)
//   done       one-cycle pulse when results are loaded
module sifh_peak_finder #(
    parameter int NB       = 8,
    parameter int PEAK_MAX = 16
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    input  logic [PEAK_MAX-1:0] minCount,
    input  logic [PEAK_MAX-1:0] counts,
    output logic [NB-1:0]       raddr,
    output logic                rEnable,
    output logic                readFlag,
    output logic [NB-1:0]       waddr,
    output logic                wEnable,
    output logic                writeFlag,
    output logic [PEAK_MAX-1:0] wdata,
    output logic [NB-1:0]       peakAddr,
    output logic [PEAK_MAX-1:0] peakCount,
    output logic                peakValid,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [NB-1:0] LAST_ADDR = {NB{1'b1}};

    state_t              state_q;
    logic [NB-1:0]       raddr_q;
    logic                ren_q;
    // Address/valid delayed one cycle so they line up with the RAM read data.
    logic [NB-1:0]       dly_addr_q;
    logic                dly_valid_q;
    logic [PEAK_MAX-1:0] max_q;
    logic [NB-1:0]       max_addr_q;
    logic [NB-1:0]       peak_addr_q;
    logic [PEAK_MAX-1:0] peak_count_q;
    logic                peak_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                upd_d;

    // Strictly greater keeps the lowest address on ties.
    always_comb begin
        upd_d = dly_valid_q && (counts > max_q);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= S_IDLE;
            raddr_q      <= '0;
            ren_q        <= 1'b0;
            dly_addr_q   <= '0;
            dly_valid_q  <= 1'b0;
            max_q        <= '0;
            max_addr_q   <= '0;
            peak_addr_q  <= '0;
            peak_count_q <= '0;
            peak_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            dly_addr_q  <= raddr_q;
            dly_valid_q <= ren_q;
            done_q      <= 1'b0;
            if (upd_d) begin
                max_q      <= counts;
                max_addr_q <= dly_addr_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_READ;
                        raddr_q    <= '0;
                        ren_q      <= 1'b1;
                        busy_q     <= 1'b1;
                        max_q      <= '0;
                        max_addr_q <= '0;
                    end
                end
                S_READ: begin
                    if (raddr_q == LAST_ADDR) begin
                        state_q <= S_DRAIN;
                        ren_q   <= 1'b0;
                    end else begin
                        raddr_q <= raddr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Wait until the last read's data has been evaluated.
                    if (!dly_valid_q) begin
                        state_q      <= S_DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        peak_addr_q  <= max_addr_q;
                        peak_count_q <= max_q;
                        peak_valid_q <= (max_q > minCount);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign raddr     = raddr_q;
    assign rEnable   = ren_q;
    assign readFlag  = ren_q;
    assign wdata     = '0;
    assign peakAddr  = peak_addr_q;
    assign peakCount = peak_count_q;
    assign peakValid = peak_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef SIFH_CLEAR_ON_READ_EN
    // Clear each bin in the same cycle its count is evaluated.
    assign waddr     = dly_addr_q;
    assign wEnable   = dly_valid_q;
    assign writeFlag = dly_valid_q;
`else
    assign waddr     = '0;
    assign wEnable   = 1'b0;
    assign writeFlag = 1'b0;
`endif

endmodule

// File: tb/tb_sifh_peak_finder.sv
// tb/tb_sifh_peak_finder.sv - randomized self-checking bench for sifh_peak_finder
module tb_sifh_peak_finder;

    localparam int NB       = 8;
    localparam int PEAK_MAX = 16;
    localparam int NBINS    = 1 << NB;

    logic                clk = 1'b0;
    logic                res;
    logic                start;
    logic [PEAK_MAX-1:0] minCount;
    logic [PEAK_MAX-1:0] counts;
    logic [NB-1:0]       raddr;
    logic                rEnable;
    logic                readFlag;
    logic [NB-1:0]       waddr;
    logic                wEnable;
    logic                writeFlag;
    logic [PEAK_MAX-1:0] wdata;
    logic [NB-1:0]       peakAddr;
    logic [PEAK_MAX-1:0] peakCount;
    logic                peakValid;
    logic                busy;
    logic                done;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Histogram RAM model: port b read with 1-cycle latency, port a write, plus a bench load port.
    logic [PEAK_MAX-1:0] mem [NBINS];
    logic [PEAK_MAX-1:0] hist [NBINS];
    logic                ld_en;
    logic [NB-1:0]       ld_addr;
    logic [PEAK_MAX-1:0] ld_data;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rEnable && readFlag) counts <= mem[raddr];
        if (wEnable && writeFlag) mem[waddr] <= wdata;
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    sifh_peak_finder #(.NB(NB), .PEAK_MAX(PEAK_MAX)) dut (
        .clk(clk), .res(res), .start(start), .minCount(minCount), .counts(counts),
        .raddr(raddr), .rEnable(rEnable), .readFlag(readFlag),
        .waddr(waddr), .wEnable(wEnable), .writeFlag(writeFlag), .wdata(wdata),
        .peakAddr(peakAddr), .peakCount(peakCount), .peakValid(peakValid),
        .busy(busy), .done(done)
    );

    // Reference: first index holding the largest value.
    function automatic void ref_peak(output int addr, output int cnt);
        addr = 0;
        cnt  = 0;
        for (int i = 0; i < NBINS; i++) begin
            if (int'(hist[i]) > cnt) begin
                cnt  = int'(hist[i]);
                addr = i;
            end
        end
    endfunction

    task automatic load_ram();
        for (int i = 0; i < NBINS; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = NB'(i);
            ld_data = hist[i];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Runs one scan; cyc = edges from the start-sampling edge to the first done, ndone = done pulses seen.
    task automatic run_scan(input bit hold, output int cyc, output int ndone);
        bit found = 0;
        cyc   = -1;
        ndone = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (!found) begin
                    found = 1;
                    cyc   = k;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic scan_and_check(input string nm, input bit hold);
        int cyc, nd, ea, ec;
        bit ev;
        ref_peak(ea, ec);
        ev = (ec > int'(minCount));
        load_ram();
        run_scan(hold, cyc, nd);
        check_cnt++;
        if (cyc !== NBINS + 2) $display("FAIL %s done_cycle got %0d want %0d", nm, cyc, NBINS + 2);
        else pass_cnt++;
        check_cnt++;
        if (nd !== 1) $display("FAIL %s done_pulses got %0d want 1", nm, nd);
        else pass_cnt++;
        check_cnt++;
        if (int'(peakAddr) !== ea) $display("FAIL %s peakAddr got %0d want %0d", nm, peakAddr, ea);
        else pass_cnt++;
        check_cnt++;
        if (int'(peakCount) !== ec) $display("FAIL %s peakCount got %0d want %0d", nm, peakCount, ec);
        else pass_cnt++;
        check_cnt++;
        if (peakValid !== ev) $display("FAIL %s peakValid got %0b want %0b", nm, peakValid, ev);
        else pass_cnt++;
        // RAM afterwards: zeroed when clear-on-read is built in, untouched otherwise.
        begin
            int bad = 0;
            for (int i = 0; i < NBINS; i++) begin
`ifdef SIFH_CLEAR_ON_READ_EN
                if (mem[i] !== '0) bad++;
`else
                if (mem[i] !== hist[i]) bad++;
`endif
            end
            check_cnt++;
            if (bad !== 0) $display("FAIL %s ram_after_scan bad_bins got %0d want 0", nm, bad);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        res = 1'b1;
        #1;
        check_cnt++;
        if ({raddr, rEnable, readFlag, waddr, wEnable, writeFlag, wdata, peakAddr, peakCount,
             peakValid, busy, done} !== '0)
            $display("FAIL reset_outputs got nonzero want 0 (raddr=%0d peakCount=%0d busy=%0b done=%0b)",
                     raddr, peakCount, busy, done);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        res = 1'b0;
    endtask

    task automatic test_single_peak();
        for (int i = 0; i < NBINS; i++) hist[i] = PEAK_MAX'($urandom_range(0, 89));
        hist[37] = 90;
        minCount = 10;
        scan_and_check("single_peak", 1'b0);
        check_cnt++;
        if (peakAddr !== 8'd37 || peakCount !== 16'd90 || peakValid !== 1'b1)
            $display("FAIL single_peak_const got %0d/%0d/%0b want 37/90/1", peakAddr, peakCount, peakValid);
        else pass_cnt++;
    endtask

    task automatic test_tie();
        for (int i = 0; i < NBINS; i++) hist[i] = PEAK_MAX'($urandom_range(0, 49));
        hist[5]   = 50;
        hist[200] = 50;
        minCount  = 50;
        scan_and_check("tie", 1'b0);
        check_cnt++;
        if (peakAddr !== 8'd5 || peakCount !== 16'd50 || peakValid !== 1'b0)
            $display("FAIL tie_const got %0d/%0d/%0b want 5/50/0", peakAddr, peakCount, peakValid);
        else pass_cnt++;
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < NBINS; i++) hist[i] = '0;
        minCount = 0;
        scan_and_check("all_zero", 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            int ea, ec;
            for (int i = 0; i < NBINS; i++)
                hist[i] = (t == 1) ? PEAK_MAX'($urandom_range(0, 40)) : PEAK_MAX'($urandom);
            ref_peak(ea, ec);
            // Straddle the threshold: equal (invalid), one below (valid), random.
            case (t)
                0: minCount = PEAK_MAX'(ec);
                1: minCount = PEAK_MAX'(ec - 1);
                default: minCount = PEAK_MAX'($urandom);
            endcase
            scan_and_check($sformatf("random%0d", t), 1'b0);
        end
    endtask

    task automatic test_reset_mid_scan();
        int guard = 0;
        int seen_done = 0;
        for (int i = 0; i < NBINS; i++) hist[i] = PEAK_MAX'($urandom_range(0, 999));
        hist[250] = 1000;
        minCount  = 500;
        load_ram();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (raddr !== 8'd100 && guard < 400) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
            guard++;
        end
        check_cnt++;
        if (guard >= 400) $display("FAIL midreset_reach_addr100 got timeout want raddr=100");
        else pass_cnt++;
        res = 1'b1;
        #1;
        check_cnt++;
        if ({raddr, rEnable, readFlag, waddr, wEnable, writeFlag, peakAddr, peakCount,
             peakValid, busy, done} !== '0)
            $display("FAIL midreset_outputs got nonzero want 0 (raddr=%0d busy=%0b)", raddr, busy);
        else pass_cnt++;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        @(negedge clk);
        res = 1'b0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check_cnt++;
        if (seen_done !== 0) $display("FAIL midreset_no_done got %0d want 0", seen_done);
        else pass_cnt++;
        scan_and_check("after_midreset", 1'b0);
    endtask

    task automatic test_start_held();
        for (int i = 0; i < NBINS; i++) hist[i] = PEAK_MAX'($urandom_range(1, 3000));
        minCount = 2999;
        scan_and_check("start_held", 1'b1);
`ifdef SIFH_CLEAR_ON_READ_EN
        begin
            int cyc, nd;
            run_scan(1'b0, cyc, nd);
            check_cnt++;
            if (peakCount !== '0 || peakValid !== 1'b0)
                $display("FAIL clear_second_scan got %0d/%0b want 0/0", peakCount, peakValid);
            else pass_cnt++;
        end
`endif
    endtask

    initial begin
        res      = 1'b1;
        start    = 1'b0;
        minCount = '0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        test_reset();
        test_single_peak();
        test_tie();
        test_all_zero();
        test_random();
        test_reset_mid_scan();
        test_start_held();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
